alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits and register count at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction word on instr is valid.
REQ-005 instr_ready  output  1  block can accept an instruction this cycle.
REQ-006 instr  input  18  instruction word, packed as [17:15] op, [14:13] rd, [12:11] rs1, [10:9] rs2, [8] imm_sel, [7:0] imm.
REQ-007 alu_a  output  8  operand A to the downstream ALU.
REQ-008 alu_b  output  8  operand B to the downstream ALU.
REQ-009 alu_opcode  output  3  opcode to the downstream ALU.
REQ-010 alu_result  input  8  combinational result returned by the ALU.
REQ-011 alu_zero  input  1  combinational zero flag returned by the ALU.
REQ-012 wb_valid  output  1  writeback result is presented on wb_data.
REQ-013 wb_ready  input  1  consumer accepts the writeback result.
REQ-014 wb_data  output  8  result written to register rd.
REQ-015 zero_flag  output  1  registered zero flag of the last completed operation.
REQ-016 dbg_addr  input  2  debug read address.
REQ-017 dbg_data  output  8  combinational read of register dbg_addr.

Function
REQ-018 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-019 In IDLE, instr_ready SHALL be 1; in EXEC and DONE, instr_ready SHALL be 0.
REQ-020 A transfer is accepted on instr_valid and instr_ready; the rising edge that accepts it SHALL latch instr into internal fields and move the FSM to EXEC.
REQ-021 In EXEC, the block SHALL drive alu_a = reg[rs1], alu_b = imm_sel ? imm : reg[rs2] and alu_opcode = op.
REQ-022 In IDLE and DONE, alu_a, alu_b and alu_opcode SHALL be 0.
REQ-023 The edge that ends EXEC SHALL write alu_result to reg[rd], load alu_zero into zero_flag and alu_result into a wb_data register, and move the FSM to DONE.
REQ-024 In DONE, wb_valid SHALL be 1; the FSM SHALL stay in DONE with wb_data stable until wb_ready = 1, then return to IDLE on that edge.
REQ-025 Latency: with wb_ready held at 1, accept at edge k gives EXEC during cycle k..k+1, wb_valid = 1 during cycle k+1..k+2, and instr_ready = 1 again after edge k+2; best-case throughput is one instruction per 3 cycles.
REQ-026 When rd equals rs1 or rs2, operands SHALL use the pre-write register value; the write takes effect at the end of EXEC.
REQ-027 Arithmetic SHALL be 8-bit modulo (wrap-around); the block adds no carry or overflow state.
REQ-028 instr_valid while instr_ready = 0 SHALL be ignored, and instr SHALL not be sampled.
REQ-029 dbg_data SHALL reflect a register write from the cycle after the write edge.

Reset
REQ-030 With rst = 1 at an edge, the block SHALL go to IDLE, clear all 4 registers, zero_flag and wb_data to 0, and so drive wb_valid = 0.
REQ-031 Reset in EXEC or DONE SHALL abandon the operation: no register write, and no wb_valid in the cycle after reset.
REQ-032 After reset deasserts, instr_ready SHALL be 1 in the first cycle.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, SHL=101, SHR=110, SLT=111), the FSM state encoding and the instr field bit positions.
REQ-034 The 4x8 register file (two combinational read ports, one debug read port, one synchronous write port, synchronous clear) SHALL be a sub-module named alu_regfile.
REQ-035 The bench SHALL connect a combinational ALU model to alu_* for closed-loop checks.

Verification
REQ-036 Load: reset, then ADD rd=1, rs1=0, imm_sel=1, imm=0x05 -> wb_data=0x05, zero_flag=0, dbg(1)=0x05, wb_valid 2 cycles after accept.
REQ-037 Zero/wrap: r1=0xFF, then ADD rd=2, rs1=1, imm=0x01 -> wb_data=0x00, zero_flag=1; SUB rd=3, rs1=1, imm=0xFF -> 0x00, zero_flag=1.
REQ-038 Hazard: r1=0x03, then SHL rd=1, rs1=1, imm=0x02 -> wb_data=0x0C, dbg(1)=0x0C; a following SLT rd=2, rs1=1, rs2=1 -> 0x00, zero_flag=1.
REQ-039 Backpressure: hold wb_ready=0 for 5 cycles in DONE -> wb_valid and wb_data stable, instr_ready=0, instr_valid pulses ignored; release -> IDLE next cycle.
REQ-040 Reset mid-op: assert rst during EXEC of ADD rd=2, imm=0x7F -> dbg(2)=0x00, wb_valid never asserted, instr_ready=1 after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue controller.
// Holds the opcode encodings, the FSM state encoding, the instruction field layout,
// and a decode helper that splits an instruction word into its fields.
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;
  localparam int INSTR_W  = 18;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int OP_MSB     = 17;
  localparam int OP_LSB     = 15;
  localparam int RD_MSB     = 14;
  localparam int RD_LSB     = 13;
  localparam int RS1_MSB    = 12;
  localparam int RS1_LSB    = 11;
  localparam int RS2_MSB    = 10;
  localparam int RS2_LSB    = 9;
  localparam int IMMSEL_BIT = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              imm_sel;
    logic [DATA_W-1:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] word);
    instr_t d;
    d.op      = word[OP_MSB:OP_LSB];
    d.rd      = word[RD_MSB:RD_LSB];
    d.rs1     = word[RS1_MSB:RS1_LSB];
    d.rs2     = word[RS2_MSB:RS2_LSB];
    d.imm_sel = word[IMMSEL_BIT];
    d.imm     = word[IMM_MSB:IMM_LSB];
    return d;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4x8 register file with two operand read ports, one debug read port,
// one write port and a synchronous clear. All reads are combinational.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Clear every register on reset, otherwise perform the single write port update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction at a time, presents its operands to an
// external combinational ALU for one cycle, writes the result back to the register
// file and holds it on the writeback port until the consumer takes it.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [DATA_W-1:0]  wb_data,
  output logic               zero_flag,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  logic [1:0]        state;
  instr_t            cur;
  logic              accept;
  logic              reg_we;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic [DATA_W-1:0] wb_data_q;
  logic              zero_q;

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign reg_we      = (state == ST_EXEC);
  assign wb_valid    = (state == ST_DONE);
  assign wb_data     = wb_data_q;
  assign zero_flag   = zero_q;

  // Operands are read before the EXEC-end write lands, so rd == rs1/rs2 sees the old value
  alu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (reg_we),
    .waddr    (cur.rd),
    .wdata    (alu_result),
    .raddr_a  (cur.rs1),
    .raddr_b  (cur.rs2),
    .dbg_addr (dbg_addr),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .dbg_data (dbg_data)
  );

  // Sequence IDLE -> EXEC -> DONE -> IDLE; EXEC always lasts exactly one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept)   state <= ST_EXEC;
        ST_EXEC:               state <= ST_DONE;
        ST_DONE: if (wb_ready) state <= ST_IDLE;
        default:               state <= ST_IDLE;
      endcase
    end
  end

  // Capture the instruction fields only on an accepted transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
    end else if (accept) begin
      cur <= decode_instr(instr);
    end
  end

  // Latch the ALU result and zero flag at the end of EXEC; held stable through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_q <= '0;
      zero_q    <= 1'b0;
    end else if (state == ST_EXEC) begin
      wb_data_q <= alu_result;
      zero_q    <= alu_zero;
    end
  end

  // Drive the ALU only while executing so it sees zeros at all other times
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    if (state == ST_EXEC) begin
      alu_a      = rdata_a;
      alu_b      = cur.imm_sel ? cur.imm : rdata_b;
      alu_opcode = cur.op;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven closed-loop bench with a combinational ALU model,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [17:0] instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_result;
  logic        alu_zero;
  logic        wb_valid;
  logic        wb_ready;
  logic [7:0]  wb_data;
  logic        zero_flag;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_regs [4];

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       imm_sel;
    logic [7:0] imm;
    logic [7:0] exp_wb;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [14];

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .zero_flag   (zero_flag),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Combinational downstream ALU model (unsigned SLT, shift amount from b[2:0])
  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_SHL: alu_result = alu_a << alu_b[2:0];
      OP_SHR: alu_result = alu_a >> alu_b[2:0];
      OP_SLT: alu_result = {7'd0, (alu_a < alu_b)};
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                              input logic [1:0] rs2, input logic imm_sel, input logic [7:0] imm,
                              input logic [7:0] exp_wb, input logic exp_zero);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm_sel = imm_sel; v.imm = imm;
    v.exp_wb = exp_wb; v.exp_zero = exp_zero;
    return v;
  endfunction

  function automatic logic [17:0] pack_instr(input logic [2:0] op, input logic [1:0] rd,
                                             input logic [1:0] rs1, input logic [1:0] rs2,
                                             input logic imm_sel, input logic [7:0] imm);
    return {op, rd, rs1, rs2, imm_sel, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic readDbg(input string name, input logic [1:0] addr, input logic [7:0] expected);
    dbg_addr = addr;
    #1;
    checkOutput(name, dbg_data, expected);
  endtask

  task automatic waitReady(input string name);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {7'd0, instr_ready}, 8'h01);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    exp_a = model_regs[v.rs1];
    exp_b = v.imm_sel ? v.imm : model_regs[v.rs2];
    wb_ready = 1'b1;
    waitReady($sformatf("v%0d ready_before", idx));
    instr       = pack_instr(v.op, v.rd, v.rs1, v.rs2, v.imm_sel, v.imm);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = '0;
    @(negedge clk);
    checkOutput($sformatf("v%0d exec_ready", idx), {7'd0, instr_ready}, 8'h00);
    checkOutput($sformatf("v%0d exec_wb_valid", idx), {7'd0, wb_valid}, 8'h00);
    checkOutput($sformatf("v%0d alu_a", idx), alu_a, exp_a);
    checkOutput($sformatf("v%0d alu_b", idx), alu_b, exp_b);
    checkOutput($sformatf("v%0d alu_opcode", idx), {5'd0, alu_opcode}, {5'd0, v.op});
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("v%0d wb_valid", idx), {7'd0, wb_valid}, 8'h01);
    checkOutput($sformatf("v%0d wb_data", idx), wb_data, v.exp_wb);
    checkOutput($sformatf("v%0d zero_flag", idx), {7'd0, zero_flag}, {7'd0, v.exp_zero});
    checkOutput($sformatf("v%0d done_alu_op", idx), {5'd0, alu_opcode}, 8'h00);
    checkOutput($sformatf("v%0d done_alu_a", idx), alu_a, 8'h00);
    readDbg($sformatf("v%0d dbg_rd", idx), v.rd, v.exp_wb);
    model_regs[v.rd] = v.exp_wb;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("v%0d ready_after", idx), {7'd0, instr_ready}, 8'h01);
    checkOutput($sformatf("v%0d wb_valid_after", idx), {7'd0, wb_valid}, 8'h00);
  endtask

  initial begin
    // Hand-computed vectors; register contents noted after each step as r0..r3
    vecs[0]  = mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 1'b0); // r1=05
    vecs[1]  = mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 8'hFF, 1'b0); // r1=FF
    vecs[2]  = mk(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 8'h00, 1'b1); // FF+01 wraps
    vecs[3]  = mk(OP_SUB, 2'd3, 2'd1, 2'd0, 1'b1, 8'hFF, 8'h00, 1'b1); // FF-FF
    vecs[4]  = mk(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h03, 8'h03, 1'b0); // r1=03
    vecs[5]  = mk(OP_SHL, 2'd1, 2'd1, 2'd0, 1'b1, 8'h02, 8'h0C, 1'b0); // rd==rs1, r1=0C
    vecs[6]  = mk(OP_SLT, 2'd2, 2'd1, 2'd1, 1'b0, 8'h00, 8'h00, 1'b1); // 0C<0C false
    vecs[7]  = mk(OP_AND, 2'd0, 2'd1, 2'd0, 1'b1, 8'h0A, 8'h08, 1'b0); // r0=08
    vecs[8]  = mk(OP_OR,  2'd3, 2'd0, 2'd1, 1'b0, 8'h00, 8'h0C, 1'b0); // 08|0C, r3=0C
    vecs[9]  = mk(OP_SHR, 2'd2, 2'd3, 2'd0, 1'b1, 8'h02, 8'h03, 1'b0); // r2=03
    vecs[10] = mk(OP_SUB, 2'd0, 2'd2, 2'd1, 1'b0, 8'h00, 8'hF7, 1'b0); // 03-0C wraps, r0=F7
    vecs[11] = mk(OP_XOR, 2'd3, 2'd0, 2'd0, 1'b1, 8'hF7, 8'h00, 1'b1); // r3=00
    vecs[12] = mk(OP_SLT, 2'd0, 2'd3, 2'd2, 1'b0, 8'h00, 8'h01, 1'b0); // 00<03, r0=01
    vecs[13] = mk(OP_XOR, 2'd2, 2'd2, 2'd1, 1'b0, 8'h00, 8'h0F, 1'b0); // 03^0C, r2=0F

    for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;

    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    wb_ready    = 1'b1;
    dbg_addr    = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset instr_ready", {7'd0, instr_ready}, 8'h01);
    checkOutput("reset wb_valid", {7'd0, wb_valid}, 8'h00);
    checkOutput("reset wb_data", wb_data, 8'h00);
    checkOutput("reset zero_flag", {7'd0, zero_flag}, 8'h00);
    checkOutput("reset alu_a", alu_a, 8'h00);
    checkOutput("reset alu_b", alu_b, 8'h00);
    for (int i = 0; i < 4; i++) readDbg($sformatf("reset dbg r%0d", i), i[1:0], 8'h00);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-reset instr_ready", {7'd0, instr_ready}, 8'h01);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Backpressure: r0=01, so ADD r3 = r0 + 0x11 = 0x12, held 5 cycles in DONE
    wb_ready = 1'b0;
    waitReady("bp ready_before");
    instr       = pack_instr(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h11);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d wb_valid", i), {7'd0, wb_valid}, 8'h01);
      checkOutput($sformatf("bp%0d wb_data", i), wb_data, 8'h12);
      checkOutput($sformatf("bp%0d instr_ready", i), {7'd0, instr_ready}, 8'h00);
      instr       = pack_instr(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hAA);
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
    end
    @(negedge clk);
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp release instr_ready", {7'd0, instr_ready}, 8'h01);
    checkOutput("bp release wb_valid", {7'd0, wb_valid}, 8'h00);
    readDbg("bp dbg r3", 2'd3, 8'h12);
    readDbg("bp dbg r1 untouched", 2'd1, 8'h0C);
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp no spurious accept", {7'd0, instr_ready}, 8'h01);

    // Reset during EXEC of ADD r2 = r0 + 0x7F must abandon the write
    waitReady("rst ready_before");
    instr       = pack_instr(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h7F);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst exec alu_b", alu_b, 8'h7F);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst instr_ready", {7'd0, instr_ready}, 8'h01);
    checkOutput("rst wb_data", wb_data, 8'h00);
    checkOutput("rst zero_flag", {7'd0, zero_flag}, 8'h00);
    readDbg("rst dbg r2", 2'd2, 8'h00);
    readDbg("rst dbg r3", 2'd3, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst%0d wb_valid", i), {7'd0, wb_valid}, 8'h00);
      @(negedge clk);
    end
    readDbg("rst dbg r2 later", 2'd2, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
